// File: rtl/sonic_echo_responder.sv
`timescale 1ns/1ps
// sonic_echo_responder
// Emulates the sensor end of an HC-SR04 trig/echo link. A valid trig pulse
// starts a fixed burst delay. After the delay, echo is driven high for a width
// that encodes the programmed distance, or the no-object timeout width. A
// hold-off period then follows before the next request is accepted.
module sonic_echo_responder #(
  parameter int unsigned CYC_PER_US  = 100,
  parameter int unsigned MIN_TRIG_US = 10,
  parameter int unsigned BURST_US    = 200,
  parameter int unsigned US_PER_CM   = 58,
  parameter int unsigned MIN_CM      = 2,
  parameter int unsigned MAX_CM      = 400,
  parameter int unsigned TIMEOUT_US  = 38000,
  parameter int unsigned HOLDOFF_US  = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig,
  input  logic [8:0] distance_cm,
  input  logic       obj_present,
  output logic       echo,
  output logic       busy,
  output logic       meas_done
);

  localparam logic [31:0] BURST_LAST   = 32'(BURST_US * CYC_PER_US - 1);
  localparam logic [31:0] HOLDOFF_LAST = 32'(HOLDOFF_US * CYC_PER_US - 1);
  localparam logic [31:0] TIMEOUT_CYC  = 32'(TIMEOUT_US * CYC_PER_US);
  localparam logic [31:0] ECHO_PER_CM  = 32'(US_PER_CM * CYC_PER_US);
  localparam int          WW           = $clog2(MIN_TRIG_US * CYC_PER_US + 1);
  localparam logic [WW-1:0] WIDTH_MIN  = WW'(MIN_TRIG_US * CYC_PER_US);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG_HI,
    S_BURST,
    S_ECHO,
    S_HOLDOFF
  } state_t;

  logic          r_trig_m;
  logic          r_trig_s;
  logic          r_trig_d;
  state_t        r_state;
  logic [WW-1:0] r_width;
  logic [31:0]   r_cnt;
  logic [31:0]   r_echo_w;
  logic          r_echo;
  logic          r_busy;
  logic          r_meas_done;

  logic [8:0]    w_dist_clamped;
  logic          w_no_obj;
  logic [31:0]   w_echo_w;

  // Echo width for the current inputs. The distance is widened to 32 bits
  // before the multiply so that the product cannot truncate.
  assign w_dist_clamped = (distance_cm < 9'(MIN_CM)) ? 9'(MIN_CM) : distance_cm;
  assign w_no_obj       = !obj_present || (distance_cm > 9'(MAX_CM));
  assign w_echo_w       = w_no_obj ? TIMEOUT_CYC : (32'(w_dist_clamped) * ECHO_PER_CM);

  // Two-flop synchronizer for the asynchronous trig pin, plus one delayed copy
  // that is used for rising-edge detection.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples its pre-edge value. With blocking assignments, trig would
    // ripple through the whole synchronizer in a single cycle.
    if (!rst) begin
      r_trig_m <= 1'b0;
      r_trig_s <= 1'b0;
      r_trig_d <= 1'b0;
    end else begin
      r_trig_m <= trig;
      r_trig_s <= r_trig_m;
      r_trig_d <= r_trig_s;
    end
  end

  // Request/response sequencer with registered echo, busy and meas_done.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_width     <= '0;
      r_cnt       <= '0;
      r_echo_w    <= '0;
      r_echo      <= 1'b0;
      r_busy      <= 1'b0;
      r_meas_done <= 1'b0;
    end else begin
      r_meas_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A fresh rising edge is required; a level still high from an
          // earlier request has r_trig_d set and is ignored here.
          if (r_trig_s && !r_trig_d) begin
            // The edge cycle itself is the first high cycle of the pulse.
            r_width <= WW'(1);
            r_busy  <= 1'b1;
            r_state <= S_TRIG_HI;
          end
        end
        S_TRIG_HI: begin
          if (r_trig_s) begin
            // NOTE: the width counter saturates, so a very long trig pulse
            // cannot wrap around to a value that looks too short.
            if (r_width < WIDTH_MIN) r_width <= r_width + WW'(1);
          end else if (r_width >= WIDTH_MIN) begin
            r_echo_w <= w_echo_w;
            r_cnt    <= '0;
            r_state  <= S_BURST;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_BURST: begin
          if (r_cnt == BURST_LAST) begin
            r_cnt   <= '0;
            r_echo  <= 1'b1;
            r_state <= S_ECHO;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_ECHO: begin
          if (r_cnt == r_echo_w - 32'd1) begin
            r_cnt       <= '0;
            r_echo      <= 1'b0;
            r_meas_done <= 1'b1;
            r_state     <= S_HOLDOFF;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_HOLDOFF: begin
          if (r_cnt == HOLDOFF_LAST) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: begin
          r_echo  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign echo      = r_echo;
  assign busy      = r_busy;
  assign meas_done = r_meas_done;

endmodule

// File: tb/tb_sonic_echo_responder.sv
`timescale 1ns/1ps
// Directed bench for sonic_echo_responder using reduced timing parameters:
// trig minimum 20 cycles, burst 10, hold-off 8, timeout 200, 116 cycles/cm.
module tb_sonic_echo_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       trig;
  logic [8:0] distance_cm;
  logic       obj_present;
  logic       echo;
  logic       busy;
  logic       meas_done;

  int n_checks = 0;
  int n_fail   = 0;

  int lat, width, md_cnt;
  bit md_fall, to, bmid;

  bit         obj_v  [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [8:0] dist_v [7] = '{9'd10, 9'd450, 9'd0, 9'd1, 9'd2, 9'd401, 9'd400};
  int         exp_w  [7] = '{200, 200, 232, 232, 232, 200, 46400};

  sonic_echo_responder #(
    .CYC_PER_US (2),
    .MIN_TRIG_US(10),
    .BURST_US   (5),
    .US_PER_CM  (58),
    .MIN_CM     (2),
    .MAX_CM     (400),
    .TIMEOUT_US (100),
    .HOLDOFF_US (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .trig       (trig),
    .distance_cm(distance_cm),
    .obj_present(obj_present),
    .echo       (echo),
    .busy       (busy),
    .meas_done  (meas_done)
  );

  always #5 clk = ~clk;

  // Drive a trig pulse of 'hi' cycles, then measure the response: the
  // latency from the pin falling to echo rising, the echo width, and the
  // meas_done pulses. Wait until busy drops. Called on a negedge.
  task automatic measure(input int hi, output int o_lat, output int o_width,
                         output int o_md, output bit o_md_fall, output bit o_to,
                         output bit o_bmid);
    int g;
    o_lat = 0; o_width = 0; o_md = 0; o_md_fall = 1'b0; o_to = 1'b0; o_bmid = 1'b0;
    trig = 1'b1;
    repeat (hi) @(negedge clk);
    trig = 1'b0;
    while (echo !== 1'b1 && o_lat < 100) begin
      @(negedge clk);
      o_lat++;
      if (o_lat == 5) o_bmid = busy;
      if (meas_done === 1'b1) o_md++;
    end
    if (echo !== 1'b1) begin
      o_to = 1'b1;
    end else begin
      while (echo === 1'b1 && o_width < 50000) begin
        o_width++;
        @(negedge clk);
        if (meas_done === 1'b1) o_md++;
      end
      o_md_fall = (meas_done === 1'b1) && (echo === 1'b0);
      g = 0;
      while (busy !== 1'b0 && g < 100) begin
        @(negedge clk);
        g++;
        if (meas_done === 1'b1) o_md++;
      end
      if (busy !== 1'b0 || echo !== 1'b0) o_to = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; trig = 1'b0; distance_cm = 9'd10; obj_present = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      trig = ~trig;
      @(negedge clk);
      n_checks++;
      if ({echo, busy, meas_done} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: echo=%b busy=%b meas_done=%b, expected all 0", i, echo, busy, meas_done);
      end
    end
    trig = 1'b0;
    rst  = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({echo, busy, meas_done} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_release_idle: echo=%b busy=%b meas_done=%b, expected all 0", echo, busy, meas_done);
    end
  endtask

  task automatic test_basic();
    distance_cm = 9'd10; obj_present = 1'b1;
    measure(20, lat, width, md_cnt, md_fall, to, bmid);
    n_checks++; if (to) begin n_fail++; $display("FAIL basic_timeout: got bound expired, expected a complete response"); end
    n_checks++; if (lat !== 13) begin n_fail++; $display("FAIL basic_latency: got %0d, expected 13", lat); end
    n_checks++; if (width !== 1160) begin n_fail++; $display("FAIL basic_width: got %0d, expected 1160", width); end
    n_checks++; if (md_fall !== 1'b1) begin n_fail++; $display("FAIL basic_meas_done_at_fall: got %b, expected 1", md_fall); end
    n_checks++; if (md_cnt !== 1) begin n_fail++; $display("FAIL basic_meas_done_count: got %0d, expected 1", md_cnt); end
    n_checks++; if (bmid !== 1'b1) begin n_fail++; $display("FAIL basic_busy_in_burst: got %b, expected 1", bmid); end
  endtask

  task automatic test_short_trig();
    bit seen;
    distance_cm = 9'd10; obj_present = 1'b1;
    trig = 1'b1;
    repeat (19) @(negedge clk);
    trig = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (echo === 1'b1) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL short_trig_echo: got echo seen=%b, expected 0", seen); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL short_trig_busy: got %b, expected 0", busy); end
    measure(20, lat, width, md_cnt, md_fall, to, bmid);
    n_checks++; if (to || lat !== 13) begin n_fail++; $display("FAIL short_then_valid_latency: got %0d (bound expired=%b), expected 13", lat, to); end
    n_checks++; if (width !== 1160) begin n_fail++; $display("FAIL short_then_valid_width: got %0d, expected 1160", width); end
  endtask

  task automatic test_long_trig();
    distance_cm = 9'd3; obj_present = 1'b1;
    measure(40, lat, width, md_cnt, md_fall, to, bmid);
    n_checks++; if (to || lat !== 13) begin n_fail++; $display("FAIL long_trig_latency: got %0d (bound expired=%b), expected 13", lat, to); end
    n_checks++; if (width !== 348) begin n_fail++; $display("FAIL long_trig_width: got %0d, expected 348", width); end
  endtask

  task automatic test_distance_map();
    for (int i = 0; i < 7; i++) begin
      obj_present = obj_v[i];
      distance_cm = dist_v[i];
      measure(20, lat, width, md_cnt, md_fall, to, bmid);
      n_checks++;
      if (to || width !== exp_w[i] || md_cnt !== 1) begin
        n_fail++;
        $display("FAIL distance_map[%0d] obj=%b dist=%0d: width %0d meas_done %0d (bound expired=%b), expected width %0d meas_done 1",
                 i, obj_v[i], dist_v[i], width, md_cnt, to, exp_w[i]);
      end
    end
  endtask

  task automatic test_retrigger();
    bit seen;
    int l, w;
    distance_cm = 9'd10; obj_present = 1'b1;
    trig = 1'b1;
    repeat (20) @(negedge clk);
    trig = 1'b0;
    l = 0;
    while (echo !== 1'b1 && l < 100) begin @(negedge clk); l++; end
    w = 0;
    while (echo === 1'b1 && w < 5000) begin
      w++;
      if (w == 100) begin trig = 1'b1; distance_cm = 9'd50; end
      if (w == 120) trig = 1'b0;
      @(negedge clk);
    end
    n_checks++; if (w !== 1160) begin n_fail++; $display("FAIL retrig_echo_width: got %0d, expected 1160", w); end
    trig = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (echo === 1'b1) seen = 1'b1;
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL retrig_held_level_busy: got %b, expected 0", busy); end
    trig = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (echo === 1'b1) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL retrig_not_queued: echo seen=%b busy=%b, expected 0 0", seen, busy); end
  endtask

  task automatic test_reset_mid_echo();
    int l;
    distance_cm = 9'd10; obj_present = 1'b1;
    trig = 1'b1;
    repeat (20) @(negedge clk);
    trig = 1'b0;
    l = 0;
    while (echo !== 1'b1 && l < 100) begin @(negedge clk); l++; end
    n_checks++; if (echo !== 1'b1) begin n_fail++; $display("FAIL rst_mid_reach_echo: echo=%b, expected 1", echo); end
    repeat (50) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({echo, busy, meas_done} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_mid_echo_drop: echo=%b busy=%b meas_done=%b, expected all 0", echo, busy, meas_done);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    distance_cm = 9'd4;
    measure(20, lat, width, md_cnt, md_fall, to, bmid);
    n_checks++; if (to || lat !== 13) begin n_fail++; $display("FAIL rst_mid_next_latency: got %0d (bound expired=%b), expected 13", lat, to); end
    n_checks++; if (width !== 464) begin n_fail++; $display("FAIL rst_mid_next_width: got %0d, expected 464", width); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short_trig();
    test_long_trig();
    test_distance_map();
    test_retrigger();
    test_reset_mid_echo();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached before the sequence completed");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
